id_stage_pipe: RTL and testbench

Parametrised ARM-subset instruction-decode stage with an integrated register file, condition check and output pipeline register (ID/EXE) using a valid/ready handshake. It sits between the IF/ID register and the EXE stage. It adds stall, flush and write-back bypass, and makes data width and register count configurable.

---
 rtl/id_stage_pipe.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_id_stage_pipe.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage_pipe.sv
// ---------------------------------------------------------------------------
// id_stage_pipe
//
// Decode stage for an ARM-subset pipeline. It sits between the IF/ID register
// and the EXE stage, and contains:
//   * a field extractor and opcode decoder (data-processing, LDR/STR, B)
//   * a condition check of instr[31:28] against the status flags
//   * an NREG x DW register file with write-back bypass on both read ports
//   * a single-entry ID/EXE output register with a valid/ready handshake,
//     plus hazard stall and flush
//
// Parameters
//   DW    register/data width in bits (8..64)
//   NREG  implemented registers (2..16); indices >= NREG read 0, writes dropped
//
// Ports
//   clk, rst                 clock; synchronous active-low reset
//   in_valid / in_ready      upstream handshake for instr
//   instr, sr                instruction word and status {N,Z,C,V}
//   hazard, flush            stall request and squash from the hazard unit
//   wb_en/wb_dest/wb_data    register-file write-back port
//   out_valid / out_ready    downstream handshake for the ID/EXE bundle
//   src1, src2               combinational read indices for the hazard unit
//   wb_en_o .. rn_valid      registered ID/EXE bundle
// ---------------------------------------------------------------------------
module id_stage_pipe #(
  parameter int DW   = 32,
  parameter int NREG = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   instr,
  input  logic [3:0]    sr,
  input  logic          hazard,
  input  logic          flush,
  input  logic          wb_en,
  input  logic [3:0]    wb_dest,
  input  logic [DW-1:0] wb_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [3:0]    src1,
  output logic [3:0]    src2,
  output logic          wb_en_o,
  output logic          mem_r_en,
  output logic          mem_w_en,
  output logic          b,
  output logic          s,
  output logic [3:0]    exe_cmd,
  output logic [DW-1:0] val_rn,
  output logic [DW-1:0] val_rm,
  output logic          imm,
  output logic [11:0]   shift_operand,
  output logic [23:0]   signed_imm_24,
  output logic [3:0]    dest,
  output logic          two_src,
  output logic          rn_valid
);

  // -------------------------------------------------------------------------
  // Encodings
  // -------------------------------------------------------------------------
  typedef enum logic [1:0] {
    MODE_DP  = 2'b00,
    MODE_MEM = 2'b01,
    MODE_BR  = 2'b10
  } mode_e;

  typedef enum logic [3:0] {
    OP_AND = 4'b0000,
    OP_EOR = 4'b0001,
    OP_SUB = 4'b0010,
    OP_ADD = 4'b0100,
    OP_ADC = 4'b0101,
    OP_SBC = 4'b0110,
    OP_TST = 4'b1000,
    OP_CMP = 4'b1010,
    OP_ORR = 4'b1100,
    OP_MOV = 4'b1101,
    OP_MVN = 4'b1111
  } opcode_e;

  typedef enum logic [3:0] {
    CMD_NONE = 4'b0000,
    CMD_MOV  = 4'b0001,
    CMD_ADD  = 4'b0010,
    CMD_ADC  = 4'b0011,
    CMD_SUB  = 4'b0100,
    CMD_SBC  = 4'b0101,
    CMD_AND  = 4'b0110,
    CMD_ORR  = 4'b0111,
    CMD_EOR  = 4'b1000,
    CMD_MVN  = 4'b1001
  } exe_cmd_e;

  typedef enum logic [3:0] {
    CC_EQ, CC_NE, CC_CS, CC_CC, CC_MI, CC_PL, CC_VS, CC_VC,
    CC_HI, CC_LS, CC_GE, CC_LT, CC_GT, CC_LE, CC_AL, CC_NV
  } cond_e;

  typedef struct packed {
    logic     wb_en;
    logic     mem_r_en;
    logic     mem_w_en;
    logic     b;
    logic     s;
    exe_cmd_e exe_cmd;
  } ctrl_t;

  // -------------------------------------------------------------------------
  // Field extraction
  // -------------------------------------------------------------------------
  mode_e   mode;
  opcode_e opcode;
  cond_e   cond;
  logic    s_bit;
  logic    is_store;

  assign mode     = mode_e'(instr[27:26]);
  assign opcode   = opcode_e'(instr[24:21]);
  assign cond     = cond_e'(instr[31:28]);
  assign s_bit    = instr[20];
  assign is_store = (mode == MODE_MEM) && !s_bit;

  // A store reads its data register through the second port, so the hazard
  // unit must see Rd rather than Rm on src2.
  assign src1 = instr[19:16];
  assign src2 = is_store ? instr[15:12] : instr[3:0];

  // -------------------------------------------------------------------------
  // Opcode decode
  // -------------------------------------------------------------------------
  ctrl_t ctrl;
  logic  rn_used;

  // NOTE: every signal assigned in an always_comb gets a default on entry;
  // otherwise a path that skips it would infer a latch.
  always_comb begin
    ctrl    = '0;
    rn_used = 1'b1;
    unique case (mode)
      MODE_DP: begin
        ctrl.wb_en = 1'b1;
        ctrl.s     = s_bit;
        case (opcode)
          OP_MOV: begin ctrl.exe_cmd = CMD_MOV; rn_used = 1'b0; end
          OP_MVN: begin ctrl.exe_cmd = CMD_MVN; rn_used = 1'b0; end
          OP_ADD: ctrl.exe_cmd = CMD_ADD;
          OP_ADC: ctrl.exe_cmd = CMD_ADC;
          OP_SUB: ctrl.exe_cmd = CMD_SUB;
          OP_SBC: ctrl.exe_cmd = CMD_SBC;
          OP_AND: ctrl.exe_cmd = CMD_AND;
          OP_ORR: ctrl.exe_cmd = CMD_ORR;
          OP_EOR: ctrl.exe_cmd = CMD_EOR;
          // Compares only set flags: no write-back, S always on.
          OP_CMP: begin ctrl.exe_cmd = CMD_SUB; ctrl.wb_en = 1'b0; ctrl.s = 1'b1; end
          OP_TST: begin ctrl.exe_cmd = CMD_AND; ctrl.wb_en = 1'b0; ctrl.s = 1'b1; end
          default: ctrl = '0;
        endcase
      end
      MODE_MEM: begin
        // Address is Rn + offset for both loads and stores; S selects LDR.
        ctrl.exe_cmd  = CMD_ADD;
        ctrl.s        = s_bit;
        ctrl.wb_en    = s_bit;
        ctrl.mem_r_en = s_bit;
        ctrl.mem_w_en = !s_bit;
      end
      MODE_BR: begin
        // Only the branch flag is raised; instr[20] is offset, not S.
        ctrl.b  = 1'b1;
        rn_used = 1'b0;
      end
      default: ctrl = '0;
    endcase
  end

  // -------------------------------------------------------------------------
  // Condition check
  // -------------------------------------------------------------------------
  logic flag_n, flag_z, flag_c, flag_v;
  logic cond_pass;

  assign {flag_n, flag_z, flag_c, flag_v} = sr;

  always_comb begin
    cond_pass = 1'b0;
    case (cond)
      CC_EQ: cond_pass = flag_z;
      CC_NE: cond_pass = !flag_z;
      CC_CS: cond_pass = flag_c;
      CC_CC: cond_pass = !flag_c;
      CC_MI: cond_pass = flag_n;
      CC_PL: cond_pass = !flag_n;
      CC_VS: cond_pass = flag_v;
      CC_VC: cond_pass = !flag_v;
      CC_HI: cond_pass = flag_c && !flag_z;
      CC_LS: cond_pass = !flag_c || flag_z;
      CC_GE: cond_pass = (flag_n == flag_v);
      CC_LT: cond_pass = (flag_n != flag_v);
      CC_GT: cond_pass = !flag_z && (flag_n == flag_v);
      CC_LE: cond_pass = flag_z || (flag_n != flag_v);
      CC_AL: cond_pass = 1'b1;
      default: cond_pass = 1'b0;  // NV never executes
    endcase
  end

  // A failed condition still travels down the pipe, just with no side effects.
  ctrl_t ctrl_eff;
  assign ctrl_eff = cond_pass ? ctrl : '0;

  // -------------------------------------------------------------------------
  // Register file
  // -------------------------------------------------------------------------
  logic [DW-1:0] rf [16];

  // NOTE: the register file is reset entry by entry, so it maps to flops and
  // never to a RAM macro. Entries at or above NREG are never written and stay
  // at zero, leaving them as constants.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 16; i++) begin
      if (!rst) begin
        rf[i] <= '0;
      end else if (wb_en && (wb_dest == 4'(i)) && (i < NREG)) begin
        rf[i] <= wb_data;
      end
    end
  end

  // Same-cycle write-back is forwarded so a reader sees the value being written.
  logic [DW-1:0] rn_data, rm_data;

  assign rn_data = (int'(src1) >= NREG)            ? '0      :
                   (wb_en && (wb_dest == src1))    ? wb_data : rf[src1];
  assign rm_data = (int'(src2) >= NREG)            ? '0      :
                   (wb_en && (wb_dest == src2))    ? wb_data : rf[src2];

  // -------------------------------------------------------------------------
  // Handshake and ID/EXE register
  // -------------------------------------------------------------------------
  logic accept;

  assign in_ready = rst && !hazard && !flush && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid     <= 1'b0;
      wb_en_o       <= 1'b0;
      mem_r_en      <= 1'b0;
      mem_w_en      <= 1'b0;
      b             <= 1'b0;
      s             <= 1'b0;
      exe_cmd       <= '0;
      val_rn        <= '0;
      val_rm        <= '0;
      imm           <= 1'b0;
      shift_operand <= '0;
      signed_imm_24 <= '0;
      dest          <= '0;
      two_src       <= 1'b0;
      rn_valid      <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid     <= 1'b1;
      wb_en_o       <= ctrl_eff.wb_en;
      mem_r_en      <= ctrl_eff.mem_r_en;
      mem_w_en      <= ctrl_eff.mem_w_en;
      b             <= ctrl_eff.b;
      s             <= ctrl_eff.s;
      exe_cmd       <= ctrl_eff.exe_cmd;
      val_rn        <= rn_data;
      val_rm        <= rm_data;
      imm           <= instr[25];
      shift_operand <= instr[11:0];
      signed_imm_24 <= instr[23:0];
      dest          <= instr[15:12];
      two_src       <= !instr[25] || is_store;
      rn_valid      <= rn_used;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_id_stage_pipe.sv
// ---------------------------------------------------------------------------
// tb_id_stage_pipe
//
// Directed scenarios followed by randomized traffic on a DW=32/NREG=16 stage,
// checked cycle by cycle against a behavioural model (flag table, opcode table,
// array register file, single-slot output). A second DW=16/NREG=8 instance
// checks that unimplemented registers read as zero.
// ---------------------------------------------------------------------------
module tb_id_stage_pipe;

  localparam int DW   = 32;
  localparam int NREG = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT
  logic          rst, in_valid, hazard, flush, wb_en, out_ready;
  logic [31:0]   instr;
  logic [3:0]    sr, wb_dest;
  logic [DW-1:0] wb_data;
  logic          in_ready, out_valid;
  logic [3:0]    src1, src2;
  logic          wb_en_o, mem_r_en, mem_w_en, b, s, imm, two_src, rn_valid;
  logic [3:0]    exe_cmd, dest;
  logic [DW-1:0] val_rn, val_rm;
  logic [11:0]   shift_operand;
  logic [23:0]   signed_imm_24;

  id_stage_pipe #(.DW(DW), .NREG(NREG)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .sr(sr), .hazard(hazard), .flush(flush),
    .wb_en(wb_en), .wb_dest(wb_dest), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .src1(src1), .src2(src2),
    .wb_en_o(wb_en_o), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .b(b), .s(s),
    .exe_cmd(exe_cmd), .val_rn(val_rn), .val_rm(val_rm), .imm(imm),
    .shift_operand(shift_operand), .signed_imm_24(signed_imm_24), .dest(dest),
    .two_src(two_src), .rn_valid(rn_valid)
  );

  // Small DUT: NREG=8, DW=16
  logic        s_rst, s_in_valid, s_in_ready, s_wb_en, s_out_valid;
  logic        s_hazard, s_flush, s_out_ready;
  logic [31:0] s_instr;
  logic [3:0]  s_sr, s_wb_dest, s_src1, s_src2, s_exe_cmd, s_dest;
  logic [15:0] s_wb_data, s_val_rn, s_val_rm;
  logic        s_wb_en_o, s_mem_r_en, s_mem_w_en, s_b, s_s, s_imm, s_two_src, s_rn_valid;
  logic [11:0] s_shift_operand;
  logic [23:0] s_signed_imm_24;

  id_stage_pipe #(.DW(16), .NREG(8)) u_small (
    .clk(clk), .rst(s_rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .instr(s_instr), .sr(s_sr), .hazard(s_hazard), .flush(s_flush),
    .wb_en(s_wb_en), .wb_dest(s_wb_dest), .wb_data(s_wb_data),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .src1(s_src1), .src2(s_src2),
    .wb_en_o(s_wb_en_o), .mem_r_en(s_mem_r_en), .mem_w_en(s_mem_w_en), .b(s_b), .s(s_s),
    .exe_cmd(s_exe_cmd), .val_rn(s_val_rn), .val_rm(s_val_rm), .imm(s_imm),
    .shift_operand(s_shift_operand), .signed_imm_24(s_signed_imm_24), .dest(s_dest),
    .two_src(s_two_src), .rn_valid(s_rn_valid)
  );

  // -------------------------------------------------------------------------
  // Scoring
  // -------------------------------------------------------------------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [255:0] obs_v, input logic [255:0] exp_v);
    checks++;
    assert (obs_v === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs_v, exp_v);
    end
  endtask

  // -------------------------------------------------------------------------
  // Reference model
  // -------------------------------------------------------------------------
  typedef struct packed {
    logic          wb, mr, mw, br, sf;
    logic [3:0]    cmd;
    logic [DW-1:0] rn, rm;
    logic          im;
    logic [11:0]   sh;
    logic [23:0]   simm;
    logic [3:0]    rd;
    logic          two, rnv;
  } bundle_t;

  bundle_t obs;
  always_comb obs = '{wb: wb_en_o, mr: mem_r_en, mw: mem_w_en, br: b, sf: s,
                      cmd: exe_cmd, rn: val_rn, rm: val_rm, im: imm,
                      sh: shift_operand, simm: signed_imm_24, rd: dest,
                      two: two_src, rnv: rn_valid};

  // exe_cmd per data-processing opcode, -1 where the opcode is not supported.
  int cmd_of [16] = '{6, 8, 4, -1, 2, 3, 5, -1, 6, -1, 4, -1, 7, 1, -1, 9};

  bundle_t       m_out;
  logic          m_valid;
  logic [DW-1:0] m_rf [16];

  // ARM conditions come in pairs: odd codes are the negation of the even one.
  function automatic bit cond_holds(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v, base;
    {n, z, cy, v} = f;
    if (c == 4'hF) return 1'b0;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return c[0] ? !base : base;
  endfunction

  function automatic logic [DW-1:0] read_reg(input logic [3:0] idx);
    if (int'(idx) >= NREG) return '0;
    if (wb_en && wb_dest == idx) return wb_data;
    return m_rf[idx];
  endfunction

  function automatic bit is_store(input logic [31:0] ins);
    return ins[27:26] == 2'b01 && !ins[20];
  endfunction

  function automatic logic [3:0] exp_src2(input logic [31:0] ins);
    return is_store(ins) ? ins[15:12] : ins[3:0];
  endfunction

  function automatic bundle_t model(input logic [31:0] ins, input logic [3:0] f);
    bundle_t    e;
    logic [3:0] op;
    logic       sb, is_cmp;
    e      = '0;
    op     = ins[24:21];
    sb     = ins[20];
    is_cmp = (op == 4'b1000) || (op == 4'b1010);
    e.rnv  = 1'b1;
    if (ins[27:26] == 2'b00 && cmd_of[op] >= 0) begin
      e.cmd = 4'(cmd_of[op]);
      e.wb  = !is_cmp;
      e.sf  = is_cmp ? 1'b1 : sb;
      e.rnv = !(op == 4'b1101 || op == 4'b1111);
    end else if (ins[27:26] == 2'b01) begin
      e.cmd = 4'd2;
      e.sf  = sb;
      e.wb  = sb;
      e.mr  = sb;
      e.mw  = !sb;
    end else if (ins[27:26] == 2'b10) begin
      e.br  = 1'b1;
      e.rnv = 1'b0;
    end
    if (!cond_holds(ins[31:28], f)) begin
      e.wb = 0; e.mr = 0; e.mw = 0; e.br = 0; e.sf = 0; e.cmd = '0;
    end
    e.rn   = read_reg(ins[19:16]);
    e.rm   = read_reg(exp_src2(ins));
    e.im   = ins[25];
    e.sh   = ins[11:0];
    e.simm = ins[23:0];
    e.rd   = ins[15:12];
    e.two  = !ins[25] || is_store(ins);
    return e;
  endfunction

  // One clock: check the combinational outputs for the current inputs,
  // advance the model, then check the registered outputs after the edge.
  task automatic cycle();
    logic exp_ready, acc;
    #1;
    exp_ready = rst && !hazard && !flush && (!m_valid || out_ready);
    acc       = in_valid && exp_ready;
    check("in_ready", 256'(in_ready), 256'(exp_ready));
    check("src1", 256'(src1), 256'(instr[19:16]));
    check("src2", 256'(src2), 256'(exp_src2(instr)));
    if (!rst) begin
      m_valid = 1'b0;
      m_out   = '0;
      for (int i = 0; i < 16; i++) m_rf[i] = '0;
    end else begin
      if (flush) m_valid = 1'b0;
      else if (acc) begin
        m_out   = model(instr, sr);
        m_valid = 1'b1;
      end else if (out_ready) m_valid = 1'b0;
      if (wb_en && int'(wb_dest) < NREG) m_rf[wb_dest] = wb_data;
    end
    @(posedge clk);
    #1;
    check("out_valid", 256'(out_valid), 256'(m_valid));
    check("bundle", 256'(obs), 256'(m_out));
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(0, 2) != 0) r[31:28] = 4'hE;
    return r;
  endfunction

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  bundle_t saved;

  initial begin
    rst = 0; in_valid = 0; hazard = 0; flush = 0; wb_en = 0; out_ready = 1;
    instr = '0; sr = '0; wb_dest = '0; wb_data = '0;
    m_valid = 0; m_out = '0;
    for (int i = 0; i < 16; i++) m_rf[i] = '0;

    // Small instance: a write to R12 is dropped and R12 reads as zero.
    s_rst = 0; s_in_valid = 0; s_hazard = 0; s_flush = 0; s_out_ready = 1;
    s_instr = '0; s_sr = '0; s_wb_en = 0; s_wb_dest = '0; s_wb_data = '0;
    @(posedge clk); #1;
    s_rst = 1; s_wb_en = 1; s_wb_dest = 4'd12; s_wb_data = 16'hABCD;
    @(posedge clk); #1;
    s_wb_dest = 4'd3; s_wb_data = 16'h1234;
    @(posedge clk); #1;
    s_wb_en = 0; s_in_valid = 1; s_instr = 32'hE08C5003;  // ADD R5,R12,R3
    #1;
    check("small_in_ready", 256'(s_in_ready), 256'(1'b1));
    @(posedge clk); #1;
    s_in_valid = 0;
    check("small_out_valid", 256'(s_out_valid), 256'(1'b1));
    check("small_r12_zero", 256'(s_val_rn), 256'(16'h0000));
    check("small_r3", 256'(s_val_rm), 256'(16'h1234));

    // Reset
    cycle();
    cycle();
    check("rst_out_valid", 256'(out_valid), 256'(1'b0));
    check("rst_exe_cmd", 256'(exe_cmd), 256'(4'b0000));

    // R1=5, R2=7, then ADD R3,R1,R2
    rst = 1;
    wb_en = 1; wb_dest = 4'd1; wb_data = 32'd5; cycle();
    wb_dest = 4'd2; wb_data = 32'd7; cycle();
    wb_en = 0; in_valid = 1; instr = 32'hE0813002; sr = 4'b0000; cycle();
    check("add_out_valid", 256'(out_valid), 256'(1'b1));
    check("add_exe_cmd", 256'(exe_cmd), 256'(4'b0010));
    check("add_wb_en_o", 256'(wb_en_o), 256'(1'b1));
    check("add_val_rn", 256'(val_rn), 256'(32'd5));
    check("add_val_rm", 256'(val_rm), 256'(32'd7));
    check("add_dest", 256'(dest), 256'(4'd3));

    // Write-back bypass: R1<=9 in the accept cycle
    wb_en = 1; wb_dest = 4'd1; wb_data = 32'd9; cycle();
    wb_en = 0;
    check("bypass_val_rn", 256'(val_rn), 256'(32'd9));

    // ADDEQ with Z=0 then Z=1
    instr = 32'h00813002; sr = 4'b0000; cycle();
    check("addeq_f_valid", 256'(out_valid), 256'(1'b1));
    check("addeq_f_wb", 256'(wb_en_o), 256'(1'b0));
    check("addeq_f_cmd", 256'(exe_cmd), 256'(4'b0000));
    sr = 4'b0100; cycle();
    check("addeq_t_wb", 256'(wb_en_o), 256'(1'b1));

    // Backpressure for 3 cycles, then release
    saved = obs;
    out_ready = 0; instr = 32'hE0823001;  // ADD R3,R2,R1
    repeat (3) begin
      cycle();
      check("bp_in_ready", 256'(in_ready), 256'(1'b0));
      check("bp_hold", 256'(obs), 256'(saved));
    end
    out_ready = 1; cycle();
    check("bp_release_valid", 256'(out_valid), 256'(1'b1));
    check("bp_release_rn", 256'(val_rn), 256'(32'd7));
    check("bp_release_rm", 256'(val_rm), 256'(32'd9));

    // One-cycle hazard gives one bubble
    hazard = 1; instr = 32'hE0813002; cycle();
    check("hazard_bubble", 256'(out_valid), 256'(1'b0));
    hazard = 0; cycle();
    check("hazard_resume", 256'(out_valid), 256'(1'b1));

    // Flush drops the offered instruction
    flush = 1; instr = 32'hE0814002; cycle();
    check("flush_valid", 256'(out_valid), 256'(1'b0));
    flush = 0; in_valid = 0; cycle();
    check("flush_dropped", 256'(out_valid), 256'(1'b0));

    // STR R4,[R1]
    in_valid = 1; instr = 32'hE5814000; sr = 4'b0000;
    #1;
    check("str_src2", 256'(src2), 256'(4'd4));
    cycle();
    check("str_mem_w_en", 256'(mem_w_en), 256'(1'b1));
    check("str_two_src", 256'(two_src), 256'(1'b1));
    in_valid = 0; cycle();

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      hazard    = ($urandom_range(0, 9) == 0);
      flush     = ($urandom_range(0, 11) == 0);
      wb_en     = 1'($urandom_range(0, 1));
      wb_dest   = 4'($urandom_range(0, 15));
      wb_data   = $urandom;
      sr        = 4'($urandom_range(0, 15));
      instr     = rand_instr();
      cycle();
    end

    // Reset while an output is held
    hazard = 0; flush = 0; wb_en = 0;
    in_valid = 1; out_ready = 0; instr = 32'hE0813002; sr = 4'b0000;
    cycle();
    cycle();
    check("held_before_rst", 256'(out_valid), 256'(1'b1));
    rst = 0; cycle();
    check("midrst_valid", 256'(out_valid), 256'(1'b0));
    check("midrst_cmd", 256'(exe_cmd), 256'(4'b0000));
    check("midrst_rn", 256'(val_rn), 256'(32'd0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
